// File: rtl/multi_clk_div.sv
// multi_clk_div: NUM_CH independent run-time programmable clock/tick dividers.
// Ports: clk/rst_n; ch_en, ch_mode per channel; sync_all restart; cfg_valid/cfg_ready/
//   cfg_ch/cfg_div divisor write with cfg_err on bad channel; pending, clk_out per channel.
// Latency: outputs are registered; cfg_ready is combinational from cfg_ch and pending.

module multi_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50000000,
  parameter int CH_W        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_mode,
  input  logic              sync_all,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic              ch_ok;
  logic [NUM_CH-1:0] wr_hit;

  // Decode by comparison rather than indexing so an out-of-range cfg_ch
  // never indexes past the pending vector; such writes are always ready.
  always_comb begin
    cfg_ready = 1'b1;
    ch_ok     = 1'b0;
    wr_hit    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        ch_ok     = 1'b1;
        cfg_ready = ~pending[i];
        wr_hit[i] = cfg_valid & ~pending[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_valid & ~ch_ok;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_shadow;
    logic             pend_q;
    logic             out_q;
    logic             mode_q;
    logic             idle;
    logic             restart;
    logic             tc;
    logic             mode_chg;

    assign idle     = (div_act == '0);
    // Any of these holds the channel at cnt 0 with output low.
    assign restart  = sync_all | ~ch_en[g] | idle;
    // div_act - 1 is safe: idle covers div_act == 0.
    assign tc       = ~idle & (cnt == div_act - ONE);
    assign mode_chg = ch_mode[g] ^ mode_q;

    assign pending[g] = pend_q;
    assign clk_out[g] = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt        <= '0;
        div_act    <= DIV_RST;
        div_shadow <= '0;
        pend_q     <= 1'b0;
        out_q      <= 1'b0;
        mode_q     <= 1'b0;
      end else begin
        mode_q <= ch_mode[g];

        // A write is only accepted while nothing is pending, so staging and
        // applying can never coincide; a fresh write waits for the next trigger.
        if (wr_hit[g]) begin
          div_shadow <= cfg_div;
          pend_q     <= 1'b1;
        end else if (pend_q && (restart || tc)) begin
          div_act <= div_shadow;
          pend_q  <= 1'b0;
        end

        if (restart) begin
          cnt   <= '0;
          out_q <= 1'b0;
        end else if (tc) begin
          cnt <= '0;
          if (mode_chg)        out_q <= 1'b0;
          else if (ch_mode[g]) out_q <= 1'b1;
          else                 out_q <= ~out_q;
        end else begin
          cnt <= cnt + ONE;
          // Tick output lasts one cycle; square output holds between edges.
          if (mode_chg || ch_mode[g]) out_q <= 1'b0;
        end
      end
    end
  end

endmodule
